// File: rtl/serial_tx.sv
// Purpose : UART-style serial transmitter; start bit, DATA_W data bits LSB first, optional parity, stop bit.
// Latency : tx drops to the start level on the first clk edge after a word is accepted; a frame lasts
//           (DATA_W + 2 + (PARITY != 0)) * CLK_DIV cycles, followed by at least one idle cycle.
// Backpressure: ready is high only while idle; valid is ignored while a frame is in flight.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset; abandons any frame in progress
//   data   - word to send, sampled only on the accepting edge
//   valid  - upstream offers a word on data
//   ready  - block is idle and will accept a word on the next edge
//   tx     - serial line output, registered, idles at 1
//   busy   - frame in progress (inverse of ready)

module serial_tx #(
  parameter int DATA_W  = 8,  // data bits per frame, 1..16
  parameter int CLK_DIV = 4,  // clock cycles per serial bit, >= 1
  parameter int PARITY  = 0   // 0 = none, 1 = even, 2 = odd
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy
);

  // Counter widths are kept at least one bit so CLK_DIV=1 and DATA_W=1 still elaborate.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD_PAR = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;  // cycles spent on the current bit, 0..CLK_DIV-1
  logic [CNT_W-1:0]  bit_cnt;  // index of the data bit currently on the line
  logic [DATA_W-1:0] shreg;    // latched word, shifted right as bits go out
  logic              par_bit;  // parity of the latched word, fixed at acceptance

  logic              bit_end;
  logic [DATA_W-1:0] sh_next;

  // The current bit has been held for its full CLK_DIV cycles on this edge.
  // With CLK_DIV=1 the divider sits at 0 and every edge ends a bit.
  assign bit_end = (div_cnt == DIV_LAST);

  // tx is registered, so the next data bit is loaded onto the line from the
  // already-shifted word on the same edge that ends the current bit.
  assign sh_next = shreg >> 1;

  // ready depends only on registered state: no combinational path from valid.
  assign ready = (state == ST_IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          tx      <= 1'b1;
          if (valid) begin
            shreg   <= data;
            par_bit <= (^data) ^ ODD_PAR;
            state   <= ST_START;
            tx      <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end) begin
            div_cnt <= '0;
            state   <= ST_DATA;
            tx      <= shreg[0];
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              // Last data bit done: counter wraps so the next frame starts at bit 0.
              bit_cnt <= '0;
              if (HAS_PAR) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
              shreg   <= sh_next;
              tx      <= sh_next[0];
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            div_cnt <= '0;
            state   <= ST_STOP;
            tx      <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        ST_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            // Always pass through IDLE for one cycle, giving the F+1 start-to-start spacing.
            div_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        default: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= ST_IDLE;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: several parameterisations run side by side, each compared every
// cycle against a queue of expected line levels built from the frame rules, plus
// hand-computed frames for specific words.

module tb_serial_tx;

  localparam int NI = 5;

  function automatic int dw_of(input int g);
    case (g)
      3:       return 4;
      4:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int cd_of(input int g);
    case (g)
      3:       return 1;
      4:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int pa_of(input int g);
    case (g)
      1:       return 1;
      2:       return 2;
      4:       return 2;
      default: return 0;
    endcase
  endfunction

  logic          clk;
  logic          reset;
  logic [NI-1:0] valid;
  logic [NI-1:0] ready;
  logic [NI-1:0] tx;
  logic [NI-1:0] busy;
  logic [15:0]   data_bus [NI];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int DW = dw_of(g);
    localparam int CD = cd_of(g);
    localparam int PA = pa_of(g);

    serial_tx #(
      .DATA_W (DW),
      .CLK_DIV(CD),
      .PARITY (PA)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .data (data_bus[g][DW-1:0]),
      .valid(valid[g]),
      .ready(ready[g]),
      .tx   (tx[g]),
      .busy (busy[g])
    );

    // Expected line level for each upcoming cycle; empty means idle.
    bit exp_q[$];

    always @(posedge clk or posedge reset) begin
      logic [15:0] w;
      logic        p;
      if (reset) begin
        exp_q.delete();
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (valid[g]) begin
        w = data_bus[g];
        p = 1'b0;
        for (int i = 0; i < DW; i++) p = p ^ w[i];
        if (PA == 2) p = ~p;
        repeat (CD) exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) repeat (CD) exp_q.push_back(w[i]);
        if (PA != 0) repeat (CD) exp_q.push_back(p);
        repeat (CD) exp_q.push_back(1'b1);
      end
    end

    always @(negedge clk) begin
      logic e_tx;
      logic e_idle;
      e_idle = (exp_q.size() == 0);
      e_tx   = e_idle ? 1'b1 : exp_q[0];
      chk($sformatf("inst%0d tx/ready/busy", g),
          {61'd0, tx[g], ready[g], busy[g]},
          {61'd0, e_tx, e_idle, !e_idle});
    end
  end

  // Offer one word on instance g, then record tx for n cycles after acceptance.
  // Called away from clock edges; returns just after a falling edge.
  task automatic send_capture(input int g, input logic [15:0] w, input int n,
                              output logic [63:0] cap, output int rlow);
    cap  = '0;
    rlow = 0;
    valid[g]    = 1'b1;
    data_bus[g] = w;
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap[i] = tx[g];
      if (!ready[g]) rlow++;
      if (i == 0) valid[g] = 1'b0;
    end
  endtask

  logic [63:0] cap;
  int          rl;
  logic        gap_rdy;

  initial begin
    reset = 1'b0;
    valid = '0;
    for (int g = 0; g < NI; g++) data_bus[g] = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    chk("reset tx", tx, 5'h1F);
    chk("reset ready", ready, 5'h1F);
    chk("reset busy", busy, 5'h00);

    repeat (20) begin
      @(negedge clk);
      chk("idle tx", tx, 5'h1F);
      chk("idle ready", ready, 5'h1F);
      chk("idle busy", busy, 5'h00);
    end

    // 8'hA5, 8N1 at CLK_DIV=4
    send_capture(0, 16'h00A5, 41, cap, rl);
    chk("A5 frame", cap[39:0], 40'hFF0F00F0F0);
    chk("A5 ready low cycles", rl, 40);
    chk("A5 idle after frame", cap[40], 1'b1);

    // 8'h07 with even then odd parity
    send_capture(1, 16'h0007, 45, cap, rl);
    chk("07 even frame", cap[43:0], 44'hFF00000FFF0);
    chk("07 even parity bit", cap[39:36], 4'hF);
    chk("07 even length", rl, 44);
    send_capture(2, 16'h0007, 45, cap, rl);
    chk("07 odd parity bit", cap[39:36], 4'h0);
    chk("07 odd length", rl, 44);

    // CLK_DIV=1, DATA_W=4, 4'b1001
    send_capture(3, 16'h0009, 7, cap, rl);
    chk("1001 frame", cap[5:0], 6'b110010);
    chk("1001 ready low cycles", rl, 6);
    chk("1001 idle after frame", cap[6], 1'b1);

    // Back-to-back with valid held: 8'h01 then 8'hFF, data swapped mid-frame
    cap = '0;
    valid[0]    = 1'b1;
    data_bus[0] = 16'h0001;
    gap_rdy     = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      cap[i] = tx[0];
      if (i == 40) gap_rdy = ready[0];
      if (i == 0) data_bus[0] = 16'h00FF;
      if (i == 41) valid[0] = 1'b0;
    end
    chk("b2b first start", cap[3:0], 4'h0);
    chk("b2b first bit0", cap[7:4], 4'hF);
    chk("b2b first bits1-7 unchanged", cap[35:8], 28'h0);
    chk("b2b first stop", cap[39:36], 4'hF);
    chk("b2b gap tx", cap[40], 1'b1);
    chk("b2b gap ready", gap_rdy, 1'b1);
    chk("b2b second start", cap[44:41], 4'h0);
    chk("b2b second bit0", cap[45], 1'b1);
    repeat (45) @(negedge clk);

    // Reset during data bit 3 of 8'h00, with valid held through reset
    valid[0]    = 1'b1;
    data_bus[0] = 16'h0000;
    @(posedge clk);
    repeat (18) @(negedge clk);
    valid[0] = 1'b0;
    chk("zero frame bit3", tx[0], 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("async reset tx", tx[0], 1'b1);
    chk("async reset ready", ready[0], 1'b1);
    chk("async reset busy", busy[0], 1'b0);
    valid[0]    = 1'b1;
    data_bus[0] = 16'h003C;
    @(posedge clk);
    #1;
    chk("valid during reset ignored", ready[0], 1'b1);
    #1 reset = 1'b0;
    send_capture(0, 16'h003C, 41, cap, rl);
    chk("3C frame after reset", cap[39:0], 40'hF00FFFF000);
    chk("3C ready low cycles", rl, 40);

    // Randomised traffic on all instances, with occasional reset pulses
    repeat (4000) begin
      @(posedge clk);
      #2;
      reset = ($urandom_range(0, 599) == 0);
      for (int g = 0; g < NI; g++) begin
        valid[g]    = ($urandom_range(0, 2) != 0);
        data_bus[g] = 16'($urandom);
      end
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    valid = '0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("drained ready", ready, 5'h1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
